// File: rtl/inst_fetch_queue.sv
// Fetch stage with one outstanding request to the memory controller and a circular
// instruction queue drained by decode. Define STATIC_PREDICT_EN for static prediction.
module inst_fetch_queue #(
    parameter int unsigned IQ_SIZE_LOG = 4,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        roll_back,
    input  logic [31:0] roll_back_pc,
    output logic        fetch_start,
    output logic [31:0] fetch_pc,
    input  logic        finish_fetch,
    input  logic [31:0] instruction_in,
    output logic        issue_valid,
    input  logic        issue_ready,
    output logic [31:0] issue_inst,
    output logic [31:0] issue_pc,
    output logic        issue_pred_jump
);
    localparam int unsigned DEPTH = 2 ** IQ_SIZE_LOG;
    localparam int unsigned CW    = IQ_SIZE_LOG + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]             r_state;
    logic                   r_fetch_start;
    logic [31:0]            r_fetch_pc;
    logic [31:0]            r_next_pc;
    logic [IQ_SIZE_LOG-1:0] r_head;
    logic [IQ_SIZE_LOG-1:0] r_tail;
    logic [CW-1:0]          r_count;
    logic [31:0]            r_inst_mem [DEPTH];
    logic [31:0]            r_pc_mem   [DEPTH];

    logic        w_push;
    logic        w_pop;
    logic [31:0] w_next_pc;

    assign issue_valid = (r_count != '0);
    assign w_push      = rdy_in && !roll_back && (r_state == ST_WAIT) && finish_fetch;
    assign w_pop       = rdy_in && !roll_back && issue_valid && issue_ready;
    assign fetch_start = r_fetch_start;
    assign fetch_pc    = r_fetch_pc;

    // Head fields are gated so an empty queue presents zeros, including right after reset.
    assign issue_inst = issue_valid ? r_inst_mem[r_head] : 32'h0;
    assign issue_pc   = issue_valid ? r_pc_mem[r_head]   : 32'h0;

`ifdef STATIC_PREDICT_EN
    logic        r_pred_mem [DEPTH];
    logic [31:0] w_j_imm;
    logic [31:0] w_b_imm;
    logic        w_is_jal;
    logic        w_is_bwd_branch;
    logic        w_pred;

    assign w_j_imm = {{11{instruction_in[31]}}, instruction_in[31], instruction_in[19:12],
                      instruction_in[20], instruction_in[30:21], 1'b0};
    assign w_b_imm = {{19{instruction_in[31]}}, instruction_in[31], instruction_in[7],
                      instruction_in[30:25], instruction_in[11:8], 1'b0};
    assign w_is_jal        = (instruction_in[6:0] == 7'b1101111);
    assign w_is_bwd_branch = (instruction_in[6:0] == 7'b1100011) && instruction_in[31];
    assign w_pred          = w_is_jal || w_is_bwd_branch;

    always_comb begin
        w_next_pc = r_fetch_pc + 32'd4;
        if (w_is_jal) begin
            w_next_pc = r_fetch_pc + w_j_imm;
        end else if (w_is_bwd_branch) begin
            w_next_pc = r_fetch_pc + w_b_imm;
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_pred_mem[r_tail] <= w_pred;
        end
    end

    assign issue_pred_jump = issue_valid && r_pred_mem[r_head];
`else
    assign w_next_pc       = r_fetch_pc + 32'd4;
    assign issue_pred_jump = 1'b0;
`endif

    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_inst_mem[r_tail] <= instruction_in;
            r_pc_mem[r_tail]   <= r_fetch_pc;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state       <= ST_IDLE;
            r_fetch_start <= 1'b0;
            r_fetch_pc    <= RESET_PC;
            r_next_pc     <= RESET_PC;
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
        end else if (rdy_in) begin
            if (roll_back) begin
                r_state       <= ST_IDLE;
                r_fetch_start <= 1'b0;
                r_fetch_pc    <= roll_back_pc;
                r_head        <= '0;
                r_tail        <= '0;
                r_count       <= '0;
            end else begin
                if (w_push) begin
                    r_tail <= r_tail + IQ_SIZE_LOG'(1);
                end
                if (w_pop) begin
                    r_head <= r_head + IQ_SIZE_LOG'(1);
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + CW'(1);
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - CW'(1);
                end

                // fetch_pc only moves when leaving HOLD, so the memory side sees a stable address.
                case (r_state)
                    ST_IDLE: begin
                        if (r_count != FULL_COUNT) begin
                            r_fetch_start <= 1'b1;
                            r_state       <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (finish_fetch) begin
                            r_fetch_start <= 1'b0;
                            r_next_pc     <= w_next_pc;
                            r_state       <= ST_HOLD;
                        end
                    end
                    ST_HOLD: begin
                        r_fetch_pc <= r_next_pc;
                        r_state    <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue (depth 4): directed scenarios plus a randomized run checked
// against a queue-level reference model and an automatic memory responder.
module tb_inst_fetch_queue;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        pred;
    } entry_t;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        roll_back;
    logic [31:0] roll_back_pc;
    logic        fetch_start;
    logic [31:0] fetch_pc;
    logic        finish_fetch;
    logic [31:0] instruction_in;
    logic        issue_valid;
    logic        issue_ready;
    logic [31:0] issue_inst;
    logic [31:0] issue_pc;
    logic        issue_pred_jump;

    int checks   = 0;
    int failures = 0;

    // Reference model: expected queue contents and expected fetch interface.
    entry_t      m_q[$];
    logic [31:0] m_fpc;
    logic [31:0] m_next;
    logic        m_fstart;
    logic        m_hold;

    // Memory responder state.
    bit          auto_mem;
    int          lat_max;
    int          lat_left;
    bit          served;
    int          mem_mode;
    logic [31:0] prog [logic [31:0]];

    inst_fetch_queue #(
        .IQ_SIZE_LOG(2),
        .RESET_PC   (32'h0)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .roll_back      (roll_back),
        .roll_back_pc   (roll_back_pc),
        .fetch_start    (fetch_start),
        .fetch_pc       (fetch_pc),
        .finish_fetch   (finish_fetch),
        .instruction_in (instruction_in),
        .issue_valid    (issue_valid),
        .issue_ready    (issue_ready),
        .issue_inst     (issue_inst),
        .issue_pc       (issue_pc),
        .issue_pred_jump(issue_pred_jump)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        int unsigned r;
        if (prog.exists(a)) return prog[a];
        if (mem_mode == 0) return NOP;
        r = $urandom_range(0, 99);
        w = $urandom;
        if (r < 70)      w = NOP;
        else if (r < 80) w[6:0] = 7'b1100011;
        else if (r < 90) w[6:0] = 7'b1101111;
        else             w[6:0] = 7'b1100111;
        prog[a] = w;
        return w;
    endfunction

    // Returns {pred, next_pc} from the instruction's immediate value, computed arithmetically.
    function automatic logic [32:0] predict(input logic [31:0] pc, input logic [31:0] w);
`ifdef STATIC_PREDICT_EN
        int off;
        if (w[6:0] == 7'b1101111) begin
            off = int'(w[30:21]) * 2 + int'(w[20]) * 2048 + int'(w[19:12]) * 4096
                  - (w[31] ? 1048576 : 0);
            return {1'b1, pc + 32'(off)};
        end
        if (w[6:0] == 7'b1100011) begin
            off = int'(w[11:8]) * 2 + int'(w[30:25]) * 32 + int'(w[7]) * 2048
                  - (w[31] ? 4096 : 0);
            if (off < 0) return {1'b1, pc + 32'(off)};
        end
`endif
        return {1'b0, pc + 32'd4};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_fpc    = 32'h0;
        m_next   = 32'h0;
        m_fstart = 1'b0;
        m_hold   = 1'b0;
        served   = 1'b0;
        lat_left = 0;
    endtask

    // One clock: memory responder drives inputs, edge, model update, settle 1 time unit.
    task automatic cycle();
        logic        push;
        logic        pop;
        int          sz;
        logic [32:0] pn;
        entry_t      e;
        if (auto_mem) begin
            if (!rdy_in) begin
                finish_fetch = 1'b0;
            end else if (fetch_start && !served) begin
                if (lat_left == 0) begin
                    finish_fetch   = 1'b1;
                    instruction_in = mem_word(fetch_pc);
                    served         = 1'b1;
                end else begin
                    finish_fetch = 1'b0;
                    lat_left--;
                end
            end else begin
                finish_fetch = 1'b0;
                if (!fetch_start) begin
                    served   = 1'b0;
                    lat_left = int'($urandom_range(0, lat_max));
                end
            end
        end
        push = rdy_in && !roll_back && m_fstart && finish_fetch;
        pop  = rdy_in && !roll_back && (m_q.size() != 0) && issue_ready;
        sz   = m_q.size();
        @(posedge clk_in);
        if (rdy_in) begin
            if (roll_back) begin
                m_q.delete();
                m_fstart = 1'b0;
                m_hold   = 1'b0;
                m_fpc    = roll_back_pc;
            end else begin
                if (pop) void'(m_q.pop_front());
                if (m_hold) begin
                    m_fpc  = m_next;
                    m_hold = 1'b0;
                end else if (push) begin
                    pn     = predict(m_fpc, instruction_in);
                    e.inst = instruction_in;
                    e.pc   = m_fpc;
                    e.pred = pn[32];
                    m_q.push_back(e);
                    m_next   = pn[31:0];
                    m_hold   = 1'b1;
                    m_fstart = 1'b0;
                end else if (!m_fstart && sz < DEPTH) begin
                    m_fstart = 1'b1;
                end
            end
        end
        #1;
    endtask

    task automatic wait_start(input int limit, input string tag);
        int n;
        n = 0;
        while (!fetch_start && n < limit) begin
            cycle();
            n++;
        end
        if (!fetch_start) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: fetch_start still %b after %0d cycles", tag, fetch_start, n);
        end
    endtask

    task automatic do_roll_back(input logic [31:0] pc);
        roll_back    = 1'b1;
        roll_back_pc = pc;
        cycle();
        roll_back    = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        model_reset();
        repeat (2) @(posedge clk_in);
        #1;
        checks++; if (fetch_start !== 1'b0) begin failures++; $display("FAIL reset_fetch_start: got %b want 0", fetch_start); end
        checks++; if (fetch_pc !== 32'h0) begin failures++; $display("FAIL reset_fetch_pc: got %h want 0", fetch_pc); end
        checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL reset_issue_valid: got %b want 0", issue_valid); end
        checks++; if (issue_inst !== 32'h0) begin failures++; $display("FAIL reset_issue_inst: got %h want 0", issue_inst); end
        checks++; if (issue_pc !== 32'h0) begin failures++; $display("FAIL reset_issue_pc: got %h want 0", issue_pc); end
        checks++; if (issue_pred_jump !== 1'b0) begin failures++; $display("FAIL reset_pred: got %b want 0", issue_pred_jump); end
        rst_in = 1'b0;
        cycle();
        checks++; if (fetch_start !== 1'b1) begin failures++; $display("FAIL first_request: got %b want 1", fetch_start); end
    endtask

    task automatic test_nop_stream();
        int npop;
        npop        = 0;
        mem_mode    = 0;
        auto_mem    = 1'b1;
        lat_max     = 0;
        issue_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (issue_valid) begin
                checks++;
                if (issue_pc !== 32'(npop * 4)) begin failures++; $display("FAIL nop_seq_pc: got %h want %h", issue_pc, 32'(npop * 4)); end
                checks++;
                if (issue_pred_jump !== 1'b0) begin failures++; $display("FAIL nop_pred: got %b want 0", issue_pred_jump); end
                npop++;
            end
            cycle();
            checks++; if (fetch_pc !== m_fpc) begin failures++; $display("FAIL nop_fetch_pc: got %h want %h", fetch_pc, m_fpc); end
            checks++; if (fetch_start !== m_fstart) begin failures++; $display("FAIL nop_fetch_start: got %b want %b", fetch_start, m_fstart); end
        end
        checks++;
        if (npop < 10) begin failures++; $display("FAIL nop_throughput: got %0d pops want >= 10", npop); end
    endtask

    task automatic test_full();
        int   pushes;
        logic prev_fs;
        issue_ready = 1'b0;
        do_roll_back(32'h40);
        pushes  = 0;
        prev_fs = fetch_start;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (prev_fs && !fetch_start) pushes++;
            prev_fs = fetch_start;
            checks++; if (fetch_start !== m_fstart) begin failures++; $display("FAIL full_fetch_start: got %b want %b", fetch_start, m_fstart); end
            if (i >= 30) begin
                checks++; if (fetch_start !== 1'b0) begin failures++; $display("FAIL full_stall: got %b want 0", fetch_start); end
            end
        end
        checks++; if (pushes !== DEPTH) begin failures++; $display("FAIL full_push_count: got %0d want %0d", pushes, DEPTH); end
        checks++; if (issue_pc !== 32'h40) begin failures++; $display("FAIL full_head_pc: got %h want 00000040", issue_pc); end
        issue_ready = 1'b1;
        cycle();
        issue_ready = 1'b0;
        checks++; if (fetch_start !== 1'b0) begin failures++; $display("FAIL full_pop_edge: got %b want 0", fetch_start); end
        checks++; if (issue_pc !== 32'h44) begin failures++; $display("FAIL full_next_head: got %h want 00000044", issue_pc); end
        cycle();
        checks++; if (fetch_start !== 1'b1) begin failures++; $display("FAIL full_resume: got %b want 1", fetch_start); end
        checks++; if (fetch_pc !== 32'h50) begin failures++; $display("FAIL full_resume_pc: got %h want 00000050", fetch_pc); end
    endtask

    task automatic test_rollback();
        auto_mem     = 1'b0;
        finish_fetch = 1'b0;
        issue_ready  = 1'b0;
        do_roll_back(32'h200);
        wait_start(5, "rb_start");
        finish_fetch   = 1'b1;
        instruction_in = NOP;
        roll_back      = 1'b1;
        roll_back_pc   = 32'h100;
        cycle();
        finish_fetch = 1'b0;
        roll_back    = 1'b0;
        checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL rb_dropped: got %b want 0", issue_valid); end
        checks++; if (fetch_start !== 1'b0) begin failures++; $display("FAIL rb_start_clr: got %b want 0", fetch_start); end
        cycle();
        checks++; if (fetch_start !== 1'b1) begin failures++; $display("FAIL rb_reissue: got %b want 1", fetch_start); end
        checks++; if (fetch_pc !== 32'h100) begin failures++; $display("FAIL rb_pc: got %h want 00000100", fetch_pc); end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++; if (fetch_pc !== 32'h100) begin failures++; $display("FAIL hold_wait_pc: got %h want 00000100", fetch_pc); end
        end
        finish_fetch   = 1'b1;
        instruction_in = NOP;
        cycle();
        finish_fetch = 1'b0;
        checks++; if (fetch_start !== 1'b0) begin failures++; $display("FAIL hold_start: got %b want 0", fetch_start); end
        checks++; if (fetch_pc !== 32'h100) begin failures++; $display("FAIL hold_pc: got %h want 00000100", fetch_pc); end
        checks++; if (issue_pc !== 32'h100) begin failures++; $display("FAIL hold_head_pc: got %h want 00000100", issue_pc); end
        cycle();
        checks++; if (fetch_pc !== 32'h104) begin failures++; $display("FAIL hold_after_pc: got %h want 00000104", fetch_pc); end
        checks++; if (fetch_start !== 1'b0) begin failures++; $display("FAIL hold_idle: got %b want 0", fetch_start); end
        cycle();
        checks++; if (fetch_start !== 1'b1) begin failures++; $display("FAIL hold_next_req: got %b want 1", fetch_start); end
    endtask

    task automatic test_predict();
        logic [31:0] exp_next;
        logic        exp_pred;
`ifdef STATIC_PREDICT_EN
        exp_next = 32'h1C;
        exp_pred = 1'b1;
`else
        exp_next = 32'h24;
        exp_pred = 1'b0;
`endif
        do_roll_back(32'h20);
        wait_start(5, "pred_start");
        checks++; if (fetch_pc !== 32'h20) begin failures++; $display("FAIL pred_req_pc: got %h want 00000020", fetch_pc); end
        finish_fetch   = 1'b1;
        instruction_in = 32'hFE00_0EE3;
        cycle();
        finish_fetch = 1'b0;
        checks++; if (issue_inst !== 32'hFE00_0EE3) begin failures++; $display("FAIL pred_inst: got %h want fe000ee3", issue_inst); end
        checks++; if (issue_pred_jump !== exp_pred) begin failures++; $display("FAIL pred_flag: got %b want %b", issue_pred_jump, exp_pred); end
        cycle();
        cycle();
        checks++; if (fetch_pc !== exp_next) begin failures++; $display("FAIL pred_next_pc: got %h want %h", fetch_pc, exp_next); end
    endtask

    task automatic test_freeze();
        logic        s_fs;
        logic        s_iv;
        logic [31:0] s_fpc;
        logic [31:0] s_ipc;
        do_roll_back(32'h300);
        wait_start(5, "frz_start");
        finish_fetch   = 1'b1;
        instruction_in = NOP;
        cycle();
        finish_fetch = 1'b0;
        wait_start(5, "frz_start2");
        s_fs  = fetch_start;
        s_iv  = issue_valid;
        s_fpc = fetch_pc;
        s_ipc = issue_pc;
        rdy_in       = 1'b0;
        finish_fetch = 1'b1;
        issue_ready  = 1'b1;
        roll_back    = 1'b1;
        roll_back_pc = 32'hDEAD_0000;
        for (int i = 0; i < 5; i++) begin
            cycle();
            checks++;
            if ({fetch_start, issue_valid, fetch_pc, issue_pc} !== {s_fs, s_iv, s_fpc, s_ipc}) begin
                failures++;
                $display("FAIL freeze: got %b %b %h %h want %b %b %h %h", fetch_start, issue_valid,
                         fetch_pc, issue_pc, s_fs, s_iv, s_fpc, s_ipc);
            end
        end
        rdy_in       = 1'b1;
        finish_fetch = 1'b0;
        issue_ready  = 1'b0;
        roll_back    = 1'b0;
        checks++; if (fetch_pc !== 32'h304) begin failures++; $display("FAIL freeze_pc: got %h want 00000304", fetch_pc); end
        checks++; if (issue_pc !== 32'h300) begin failures++; $display("FAIL freeze_head: got %h want 00000300", issue_pc); end
        #2;
        rst_in = 1'b1;
        #1;
        checks++; if (fetch_start !== 1'b0) begin failures++; $display("FAIL async_rst_start: got %b want 0", fetch_start); end
        checks++; if (fetch_pc !== 32'h0) begin failures++; $display("FAIL async_rst_pc: got %h want 0", fetch_pc); end
        checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL async_rst_valid: got %b want 0", issue_valid); end
        checks++; if (issue_pc !== 32'h0) begin failures++; $display("FAIL async_rst_ipc: got %h want 0", issue_pc); end
        model_reset();
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        cycle();
        checks++; if (fetch_start !== 1'b1) begin failures++; $display("FAIL post_rst_req: got %b want 1", fetch_start); end
    endtask

    task automatic test_random();
        entry_t h;
        mem_mode = 1;
        prog.delete();
        auto_mem = 1'b1;
        lat_max  = 3;
        for (int i = 0; i < 1500; i++) begin
            issue_ready  = ($urandom_range(0, 3) != 0);
            rdy_in       = ($urandom_range(0, 9) != 0);
            roll_back    = ($urandom_range(0, 39) == 0);
            roll_back_pc = $urandom & 32'hFFFF_FFFC;
            cycle();
            checks++; if (fetch_start !== m_fstart) begin failures++; $display("FAIL rnd_fetch_start @%0d: got %b want %b", i, fetch_start, m_fstart); end
            checks++; if (fetch_pc !== m_fpc) begin failures++; $display("FAIL rnd_fetch_pc @%0d: got %h want %h", i, fetch_pc, m_fpc); end
            checks++; if (issue_valid !== (m_q.size() != 0)) begin failures++; $display("FAIL rnd_valid @%0d: got %b want %b", i, issue_valid, m_q.size() != 0); end
            if (m_q.size() != 0) begin
                h = m_q[0];
                checks++;
                if ({issue_inst, issue_pc, issue_pred_jump} !== {h.inst, h.pc, h.pred}) begin
                    failures++;
                    $display("FAIL rnd_head @%0d: got %h %h %b want %h %h %b", i, issue_inst, issue_pc,
                             issue_pred_jump, h.inst, h.pc, h.pred);
                end
            end
        end
        rdy_in    = 1'b1;
        roll_back = 1'b0;
    endtask

    initial begin
        rst_in         = 1'b1;
        rdy_in         = 1'b1;
        roll_back      = 1'b0;
        roll_back_pc   = 32'h0;
        finish_fetch   = 1'b0;
        instruction_in = 32'h0;
        issue_ready    = 1'b0;
        auto_mem       = 1'b0;
        lat_max        = 0;
        mem_mode       = 0;
        test_reset();
        test_nop_stream();
        test_full();
        test_rollback();
        test_hold();
        test_predict();
        test_freeze();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
